// File: rtl/fake_n64_joybus_rx.sv
// Joybus receive front end: oversamples the console line, decodes pulse-width bits,
// assembles cmd/address/payload fields and hands the line to TX after a valid stop bit.
module fake_n64_joybus_rx #(
  parameter int CLKS_PER_US = 16,
  parameter int DATA_BYTES  = 32,
  parameter int ADDR_W      = 16
) (
  input  logic                          sample_clk,
  input  logic                          reset,
  input  logic                          cur_operation,
  input  logic                          data_rx,
  output logic [7:0]                    cmd,
  output logic [ADDR_W-1:0]             address,
  output logic [7:0]                    wr_byte,
  output logic                          wr_byte_valid,
  output logic [$clog2(DATA_BYTES)-1:0] wr_byte_idx,
  output logic                          tx_handoff,
  output logic                          frame_err,
  output logic [1:0]                    err_code
);

  localparam int IDX_W   = $clog2(DATA_BYTES);
  localparam int CNT_W   = $clog2(4*CLKS_PER_US + 1);
  localparam int MAX_LEN = 8 + ADDR_W + 8*DATA_BYTES;
  localparam int BIT_W   = $clog2(MAX_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(4*CLKS_PER_US);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(2*CLKS_PER_US);
  localparam logic [BIT_W-1:0] LEN_CMD  = BIT_W'(8);
  localparam logic [BIT_W-1:0] LAST_CMD = BIT_W'(7);
  localparam logic [BIT_W-1:0] LEN_ADDR = BIT_W'(8 + ADDR_W);
  localparam logic [BIT_W-1:0] LEN_FULL = BIT_W'(MAX_LEN);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] BIT_LOW  = 3'd1;
  localparam logic [2:0] BIT_HIGH = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] FLUSH    = 3'd4;

  logic             sync1, sync2, hist;
  logic             rise_q, fall_q;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt, exp_len;
  logic [7:0]       cmd_sh;
  logic [ADDR_W-1:0] addr_sh;
  logic [6:0]       byte_sh;
  logic [2:0]       pl_bit;
  logic [IDX_W-1:0] byte_idx;
  logic             bit_val;
  logic [7:0]       cmd_next;

  assign bit_val  = (cnt < CNT_HALF);
  assign cmd_next = {cmd_sh[6:0], bit_val};

  // Edge flags are registered so every decoded event lands three edges after the line moves.
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      // NOTE: synchroniser resets to the idle-high level so reset release never fakes a falling edge.
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      hist   <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1  <= data_rx;
      sync2  <= sync1;
      hist   <= sync2;
      rise_q <= sync2 & ~hist;
      fall_q <= ~sync2 & hist;
    end
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      exp_len       <= LEN_FULL;
      cmd_sh        <= '0;
      addr_sh       <= '0;
      byte_sh       <= '0;
      pl_bit        <= '0;
      byte_idx      <= '0;
      cmd           <= 8'hfe;
      address       <= '0;
      wr_byte       <= '0;
      wr_byte_valid <= 1'b0;
      wr_byte_idx   <= '0;
      tx_handoff    <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      // NOTE: pulses default low every cycle; the branches below only ever raise them.
      wr_byte_valid <= 1'b0;
      tx_handoff    <= 1'b0;
      frame_err     <= 1'b0;
      if (cur_operation) begin
        state    <= IDLE;
        cnt      <= '0;
        bit_cnt  <= '0;
        exp_len  <= LEN_FULL;
        cmd_sh   <= '0;
        addr_sh  <= '0;
        byte_sh  <= '0;
        pl_bit   <= '0;
        byte_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fall_q) begin
              state    <= BIT_LOW;
              cnt      <= '0;
              bit_cnt  <= '0;
              exp_len  <= LEN_FULL;
              cmd_sh   <= '0;
              addr_sh  <= '0;
              byte_sh  <= '0;
              pl_bit   <= '0;
              byte_idx <= '0;
            end
          end
          BIT_LOW: begin
            if (rise_q) begin
              state   <= BIT_HIGH;
              cnt     <= '0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < LEN_CMD) begin
                cmd_sh <= cmd_next;
                if (bit_cnt == LAST_CMD) begin
                  case (cmd_next)
                    8'h00, 8'h01, 8'hff: exp_len <= LEN_CMD;
                    8'h02:               exp_len <= LEN_ADDR;
                    8'h03:               exp_len <= LEN_FULL;
                    default: begin
                      frame_err <= 1'b1;
                      err_code  <= 2'd1;
                      state     <= FLUSH;
                    end
                  endcase
                end
              end else if (bit_cnt < LEN_ADDR) begin
                addr_sh <= {addr_sh[ADDR_W-2:0], bit_val};
              end else begin
                byte_sh <= {byte_sh[5:0], bit_val};
                pl_bit  <= pl_bit + 1'b1;
                if (pl_bit == 3'd7) begin
                  wr_byte       <= {byte_sh, bit_val};
                  wr_byte_valid <= 1'b1;
                  wr_byte_idx   <= byte_idx;
                  byte_idx      <= byte_idx + 1'b1;
                end
              end
            end else if (cnt == CNT_LIM) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= FLUSH;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BIT_HIGH: begin
            if (fall_q) begin
              cnt   <= '0;
              state <= (bit_cnt == exp_len) ? STOP : BIT_LOW;
            end else if (cnt == CNT_LIM) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (rise_q) begin
              cnt <= '0;
              if (cnt < CNT_HALF) begin
                cmd        <= cmd_sh;
                address    <= addr_sh;
                tx_handoff <= 1'b1;
                state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                err_code  <= 2'd3;
                state     <= FLUSH;
              end
            end else if (cnt == CNT_LIM) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= FLUSH;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FLUSH: begin
            // Resynchronise only after a full timeout's worth of continuous idle-high line.
            if (!hist)                cnt   <= '0;
            else if (cnt == CNT_LIM)  state <= IDLE;
            else                      cnt   <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fake_n64_joybus_rx.sv
// Scoreboard bench for fake_n64_joybus_rx: stimulus pushes expected pulse events,
// a negedge monitor pops and compares each pulse the receiver presents.
module tb_fake_n64_joybus_rx;

  localparam int CPU   = 16;
  localparam int DB    = 32;
  localparam int AW    = 16;
  localparam int IDX_W = $clog2(DB);

  logic             sample_clk = 1'b0;
  logic             reset;
  logic             cur_operation;
  logic             data_rx;
  logic [7:0]       cmd;
  logic [AW-1:0]    address;
  logic [7:0]       wr_byte;
  logic             wr_byte_valid;
  logic [IDX_W-1:0] wr_byte_idx;
  logic             tx_handoff;
  logic             frame_err;
  logic [1:0]       err_code;

  fake_n64_joybus_rx #(.CLKS_PER_US(CPU), .DATA_BYTES(DB), .ADDR_W(AW)) dut (
    .sample_clk    (sample_clk),
    .reset         (reset),
    .cur_operation (cur_operation),
    .data_rx       (data_rx),
    .cmd           (cmd),
    .address       (address),
    .wr_byte       (wr_byte),
    .wr_byte_valid (wr_byte_valid),
    .wr_byte_idx   (wr_byte_idx),
    .tx_handoff    (tx_handoff),
    .frame_err     (frame_err),
    .err_code      (err_code)
  );

  always #5 sample_clk = ~sample_clk;

  typedef enum logic [1:0] {EV_WR, EV_HANDOFF, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t         kind;
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cmd;
    logic [AW-1:0]    addr;
    logic [1:0]       code;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  passes = 0;
  int  skew   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d, input logic [IDX_W-1:0] i,
                      input logic [7:0] c, input logic [AW-1:0] a, input logic [1:0] code);
    ev_t e;
    e.kind = k; e.data = d; e.idx = i; e.cmd = c; e.addr = a; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sample_clk);
  endtask

  // One bit cell is 64 clocks (4 us); skew stretches or shrinks the low phase.
  task automatic send_bit(input logic b);
    int lo;
    lo = (b ? CPU : 3*CPU) + skew;
    data_rx = 1'b0;
    idle(lo);
    data_rx = 1'b1;
    idle(4*CPU - lo);
  endtask

  task automatic send_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    data_rx = 1'b0;
    idle(CPU);
    data_rx = 1'b1;
    idle(100);
  endtask

  always @(negedge sample_clk) begin
    if (!reset && (wr_byte_valid || tx_handoff || frame_err)) begin
      check("one_pulse", 32'($countones({wr_byte_valid, tx_handoff, frame_err})), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, wr_byte_valid, tx_handoff, frame_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        case (mon_e.kind)
          EV_WR: begin
            check("wr_byte_valid", 32'(wr_byte_valid), 32'd1);
            check("wr_byte", 32'(wr_byte), 32'(mon_e.data));
            check("wr_byte_idx", 32'(wr_byte_idx), 32'(mon_e.idx));
          end
          EV_HANDOFF: check("tx_handoff", 32'(tx_handoff), 32'd1);
          default: begin
            check("frame_err", 32'(frame_err), 32'd1);
            check("err_code", 32'(err_code), 32'(mon_e.code));
          end
        endcase
        check("cmd", 32'(cmd), 32'(mon_e.cmd));
        check("address", 32'(address), 32'(mon_e.addr));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected events pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cur_operation = 1'b0;
    data_rx = 1'b1;
    idle(3);
    check("rst_cmd", 32'(cmd), 32'h0000_00fe);
    check("rst_address", 32'(address), 32'd0);
    check("rst_pulses", {29'd0, wr_byte_valid, tx_handoff, frame_err}, 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    idle(20);

    // cmd 0x01 + stop
    push(EV_HANDOFF, 8'h00, '0, 8'h01, 16'h0000, 2'd0);
    send_word(32'h01, 8);
    send_stop();

    // cmd 0x02, address 0x8001, shortened low phases
    skew = -3;
    push(EV_HANDOFF, 8'h00, '0, 8'h02, 16'h8001, 2'd0);
    send_word(32'h02, 8);
    send_word(32'h8001, 16);
    send_stop();
    skew = 0;

    // cmd 0x03, address 0x0020, payload 0x00..0x1F; cmd/address hold until handoff
    for (int i = 0; i < DB; i++) push(EV_WR, 8'(i), IDX_W'(i), 8'h02, 16'h8001, 2'd0);
    push(EV_HANDOFF, 8'h00, '0, 8'h03, 16'h0020, 2'd0);
    send_word(32'h03, 8);
    send_word(32'h0020, 16);
    for (int i = 0; i < DB; i++) send_word(32'(i), 8);
    send_stop();

    // unknown command 0x55
    push(EV_ERR, 8'h00, '0, 8'h03, 16'h0020, 2'd1);
    send_word(32'h55, 8);
    idle(100);

    // 0x00 decodes after the error, lengthened low phases
    skew = 3;
    push(EV_HANDOFF, 8'h00, '0, 8'h00, 16'h0000, 2'd0);
    send_word(32'h00, 8);
    send_stop();
    skew = 0;

    // line left high mid-command
    push(EV_ERR, 8'h00, '0, 8'h00, 16'h0000, 2'd2);
    send_word(32'h5, 3);
    idle(100);

    // cmd 0x01 followed by a 0-bit where the stop belongs
    push(EV_ERR, 8'h00, '0, 8'h00, 16'h0000, 2'd3);
    send_word(32'h01, 8);
    send_bit(1'b0);
    idle(100);

    // TX takes the line mid-address: frame dropped silently
    send_word(32'h02, 8);
    send_word(32'hA, 4);
    cur_operation = 1'b1;
    send_word(32'h123, 12);
    send_stop();
    cur_operation = 1'b0;
    idle(20);
    check("curop_cmd", 32'(cmd), 32'h0000_0000);
    check("curop_address", 32'(address), 32'd0);

    // reset mid-payload of a 0x03 frame
    send_word(32'h03, 8);
    send_word(32'h0020, 16);
    send_word(32'h0, 4);
    reset = 1'b1;
    @(negedge sample_clk);
    check("midrst_cmd", 32'(cmd), 32'h0000_00fe);
    check("midrst_address", 32'(address), 32'd0);
    check("midrst_wr_byte", 32'(wr_byte), 32'd0);
    check("midrst_wr_byte_idx", 32'(wr_byte_idx), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(100);

    // 0xFF decodes normally after reset
    push(EV_HANDOFF, 8'h00, '0, 8'hff, 16'h0000, 2'd0);
    send_word(32'hff, 8);
    send_stop();

    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fake_n64_joybus_rx.md
# fake_n64_joybus_rx

Parametrised Joybus receive front end for the fake N64 controller. It oversamples the raw console data line on `sample_clk`, decodes pulse-width-coded bits, and assembles command, address and write-payload fields for `0x00`, `0x01`, `0x02`, `0x03` and `0xFF` frames. It also detects the console stop bit and hands the line to the TX side with a one-cycle pulse. Frame errors are reported explicitly, and the receiver resynchronises on line idle.

## Interface
- `CLKS_PER_US`, default 16: `sample_clk` cycles per microsecond; minimum 4.
- `DATA_BYTES`, default 32: write payload length for cmd `0x03`.
- `ADDR_W`, default 16: address field width.

- `sample_clk`, in, 1: the only clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `cur_operation`, in, 1: 1 = TX owns the line; the receiver is held in IDLE.
- `data_rx`, in, 1: raw asynchronous Joybus line, idle high.
- `cmd`, out, 8: last accepted command; reset `8'hfe`.
- `address`, out, `ADDR_W`: last accepted address, MSB first on the wire; reset 0.
- `wr_byte`, out, 8: payload byte; reset 0.
- `wr_byte_valid`, out, 1: one-cycle pulse per completed payload byte; reset 0.
- `wr_byte_idx`, out, `$clog2(DATA_BYTES)`: index of `wr_byte`; reset 0.
- `tx_handoff`, out, 1: one-cycle pulse when a valid frame's stop bit completes; reset 0.
- `frame_err`, out, 1: one-cycle pulse on an abandoned frame; reset 0.
- `err_code`, out, 2: held until the next `frame_err`; reset 0.
  - 1 = unknown command
  - 2 = timeout or stuck line
  - 3 = overlong frame

## Operation

**Input conditioning and edge detect**
- `data_rx` passes through a 2-flop synchroniser, then one history flop.
- Edge detection works on the synchronised signal.

**Bit decode**
- A falling edge starts a bit, and counter `cnt` counts clocks while the line is low.
- The bit commits on the rising edge.
  - Value is 1 if `cnt < 2*CLKS_PER_US`.
  - Value is 0 otherwise.
- Bits are stored MSB first.

**States**
- IDLE
  - A falling edge starts BIT_LOW, with `bit_cnt` = 0.
- BIT_LOW
  - A rising edge commits the bit, increments `bit_cnt`, and moves to BIT_HIGH.
  - If `cnt` reaches `4*CLKS_PER_US` with no rising edge: err 2, go to FLUSH.
- BIT_HIGH
  - A falling edge starts the next bit, or starts STOP if `bit_cnt` equals the expected length.
  - If the line is high for `4*CLKS_PER_US`: err 2, go to IDLE.
- STOP
  - A rising edge with `cnt < 2*CLKS_PER_US` is a valid stop.
    - Load `cmd` and `address` from the shadow registers.
    - Pulse `tx_handoff`.
    - Go to IDLE.
  - A rising edge with `cnt >= 2*CLKS_PER_US` is a data bit where a stop was expected: err 3, go to FLUSH.
  - Low for `4*CLKS_PER_US`: err 2, go to FLUSH.
- FLUSH
  - Wait for the line to be continuously high for `4*CLKS_PER_US`, then go to IDLE.
  - No other outputs change while in FLUSH.

**Field assembly**
- Bits 0–7 are the command.
  - When bit 7 commits, the expected length is fixed:
    - 8 for `0x00`, `0x01`, `0xFF`
    - `8+ADDR_W` for `0x02`
    - `8+ADDR_W+8*DATA_BYTES` for `0x03`
  - Any other command value gives err 1 and goes to FLUSH.
- Bits `8..8+ADDR_W-1` are the address (cmd `0x02`/`0x03` only).
- Payload bits after the address (cmd `0x03` only):
  - Every 8th committed bit pulses `wr_byte_valid`.
  - `wr_byte_idx` runs 0..`DATA_BYTES-1`.
  - Payload bytes stream before the stop bit; on `frame_err` the consumer discards them.

**Overrides and concurrency**
- `cur_operation` = 1 forces IDLE on the next edge.
  - Any in-progress frame is dropped silently: no `frame_err`, no pulses.
  - Shadow registers are cleared.
- `reset` mid-frame clears everything to reset values immediately; the next frame is decoded normally.
- At most one of `tx_handoff`, `frame_err`, `wr_byte_valid` is high in any cycle, except that the last payload byte and `tx_handoff` are always separated by the stop bit.

## Timing
- All pulse outputs are registered.
- Synchroniser latency:
  - `wr_byte_valid` and `tx_handoff` assert exactly 3 `sample_clk` edges after the first edge that samples `data_rx` high at the end of the relevant bit.
  - `frame_err` for timeouts asserts 1 edge after `cnt` reaches threshold.
- `cmd` and `address` change only in the `tx_handoff` cycle and are stable from that cycle onward.
- Nominal bit timing, which the decoder must accept with ±25% tolerance:
  - 0 = 3 µs low, 1 µs high
  - 1 = 1 µs low, 3 µs high
  - stop = 1 µs low, then release
- Widths:
  - `cnt` saturates at `4*CLKS_PER_US`.
  - `bit_cnt` is wide enough for `8+ADDR_W+8*DATA_BYTES+1`.

## Test plan
- Reset, then send cmd `0x01` + stop.
  - Required: `tx_handoff` one pulse, `cmd`=`0x01`, `address`=0, no `frame_err`, no `wr_byte_valid`.
- Send cmd `0x02`, address `0x8001`, stop.
  - Required: `address`=`0x8001` at the handoff pulse, `cmd`=`0x02`.
- Send cmd `0x03`, address `0x0020`, payload `0x00..0x1F`, stop.
  - Required: 32 `wr_byte_valid` pulses with `wr_byte`=`wr_byte_idx`=0..31, then `tx_handoff`.
- Send cmd `0x55`.
  - Required: `frame_err` with `err_code`=1 after the 8th bit, no `tx_handoff`.
  - Next valid `0x00` frame decodes with `cmd`=`0x00`.
- Send cmd `0x01` followed by a 0-bit instead of a stop.
  - Required: `frame_err`, `err_code`=3.
- Assert `cur_operation` mid-address of a `0x02` frame, and separately pulse `reset` mid-payload of a `0x03` frame.
  - Required: no `tx_handoff`, no `frame_err`, outputs at reset values (for `reset`).
  - The following `0xFF` frame decodes correctly.
